fpu_mul_exp_pipe: RTL

- Parametrised exponent datapath for the FPU multiply pipeline.
- Adds and re-biases the two operand exponents, then delays them to match the mantissa multiplier.
- Applies leading-zero normalisation, the normalise increment and the rounding carry.
- Produces the final exponent with per-stage valid tracking and overflow/underflow flags; sits beside the multiply fraction datapath under the multiply control block.

---
 rtl/fpu_mul_exp_pkg.sv | 34 +++
 rtl/fpu_exp_pipe_reg.sv | 30 +++
 rtl/fpu_mul_exp_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_exp_pkg.sv
// Shared encodings and helper functions for the FPU multiply exponent datapath.
// Contents: format and force encodings, bias functions, all-ones helper.
package fpu_mul_exp_pkg;

  // Operand/result format select. 11 behaves exactly like 00.
  typedef enum logic [1:0] {
    FmtWide    = 2'b00,
    FmtNar     = 2'b01,
    FmtNarWide = 2'b10,
    FmtWideAlt = 2'b11
  } fmt_e;

  // Special-value override. Both 1x codes force a zero exponent.
  typedef enum logic [1:0] {
    ForceNone    = 2'b00,
    ForceOnes    = 2'b01,
    ForceZero    = 2'b10,
    ForceZeroAlt = 2'b11
  } force_e;

  function automatic int wide_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int nar_bias(input int unsigned nar_w);
    return (1 << (nar_w - 1)) - 1;
  endfunction

  // All-ones biased exponent (inf/NaN code) for a format of the given width.
  function automatic int all_ones(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fpu_exp_pipe_reg.sv
// One pipeline stage register with valid bit, step enable and async reset.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   step          load enable; register holds when 0
//   d_vld, d      incoming valid bit and payload
//   q_vld, q      registered valid bit and payload
// Bubbles (d_vld=0) are loaded as an all-zero payload so their flags read 0.
module fpu_exp_pipe_reg #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             d_vld,
  input  logic [Width-1:0] d,
  output logic             q_vld,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
      q     <= '0;
    end else if (step) begin
      q_vld <= d_vld;
      q     <= d_vld ? d : '0;
    end
  end

endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Exponent datapath of the FPU multiply pipeline: operand capture, bias add,
// delay to match the mantissa multiplier, leading-zero adjust, normalise
// increment, rounding carry and overflow/underflow clamping.
// Ports:
//   rclk, rst            clock, asynchronous active-high reset
//   step                 advance all stages
//   in_vld, in_exp1/2    new op and its exponent fields (narrow packed at MSBs)
//   in_fmt, in_force     format select and special-value override
//   lz_cnt               leading zeros, applied to the op entering the LZ stage
//   inc_exp              normalise increment, applied entering the INC stage
//   frac_cout            rounding carry, applied entering the output register
//   to_max_fin           clamp overflow to max finite instead of infinity
//   lz_exp, lz_eq0, lz_lte0_n  exponent entering LZ stage and its compare flags
//   out_vld, out_exp, out_of, out_uf  result and flags
module fpu_mul_exp_pipe
  import fpu_mul_exp_pkg::*;
#(
  parameter int unsigned EXP_W      = 11,
  parameter int unsigned NAR_W      = 8,
  parameter int unsigned LZ_W       = 7,
  parameter int unsigned MID_STAGES = 2,
  localparam int unsigned INT_W     = EXP_W + 2
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             step,
  input  logic             in_vld,
  input  logic [EXP_W-1:0] in_exp1,
  input  logic [EXP_W-1:0] in_exp2,
  input  logic [1:0]       in_fmt,
  input  logic [1:0]       in_force,
  input  logic [LZ_W-1:0]  lz_cnt,
  input  logic             inc_exp,
  input  logic             frac_cout,
  input  logic             to_max_fin,
  output logic [INT_W-1:0] lz_exp,
  output logic             lz_eq0,
  output logic             lz_lte0_n,
  output logic             out_vld,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_of,
  output logic             out_uf
);

  localparam logic [INT_W-1:0] WideBias = INT_W'(wide_bias(EXP_W));
  localparam logic [INT_W-1:0] NarBias  = INT_W'(nar_bias(NAR_W));
  localparam logic [INT_W-1:0] WideOnes = INT_W'(all_ones(EXP_W));
  localparam logic [INT_W-1:0] NarOnes  = INT_W'(all_ones(NAR_W));

  typedef struct packed {
    logic [EXP_W-1:0] e1;
    logic [EXP_W-1:0] e2;
    fmt_e             fmt;
    force_e           frc;
  } cap_t;

  // forced: exponent already final, later stages pass it through untouched.
  typedef struct packed {
    logic [INT_W-1:0] exp;
    logic             nar_out;
    logic             forced;
    logic             uf;
  } stg_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic             of;
    logic             uf;
  } res_t;

  // S1: capture
  cap_t cap_d, cap_q;
  logic cap_vld;

  always_comb begin
    cap_d     = '0;
    cap_d.e1  = in_exp1;
    cap_d.e2  = in_exp2;
    cap_d.fmt = fmt_e'(in_fmt);
    cap_d.frc = force_e'(in_force);
  end

  fpu_exp_pipe_reg #(.Width($bits(cap_t))) u_s1 (
    .clk   (rclk),
    .rst   (rst),
    .step  (step),
    .d_vld (in_vld),
    .d     (cap_d),
    .q_vld (cap_vld),
    .q     (cap_q)
  );

  // S2: bias add. The trailing +1 accounts for the product's two integer bits.
  stg_t             bias_d;
  logic             nar_in, nar_out;
  logic [INT_W-1:0] opa, opb, bias_in, bias_out, ones_s2;

  always_comb begin
    nar_in   = (cap_q.fmt == FmtNar) || (cap_q.fmt == FmtNarWide);
    nar_out  = (cap_q.fmt == FmtNar);
    opa      = nar_in ? INT_W'(cap_q.e1 >> (EXP_W - NAR_W)) : INT_W'(cap_q.e1);
    opb      = nar_in ? INT_W'(cap_q.e2 >> (EXP_W - NAR_W)) : INT_W'(cap_q.e2);
    bias_in  = nar_in ? NarBias : WideBias;
    bias_out = nar_out ? NarBias : WideBias;
    ones_s2  = nar_out ? NarOnes : WideOnes;
    bias_d         = '0;
    bias_d.nar_out = nar_out;
    case (cap_q.frc)
      ForceOnes: begin
        bias_d.exp    = ones_s2;
        bias_d.forced = 1'b1;
      end
      ForceZero, ForceZeroAlt: begin
        bias_d.exp    = '0;
        bias_d.forced = 1'b1;
      end
      default: bias_d.exp = opa + opb - bias_in - bias_in + bias_out + INT_W'(1);
    endcase
  end

  // S2 register followed by the delay chain; dly_q[MID_STAGES] feeds LZ.
  stg_t dly_q   [MID_STAGES+1];
  logic dly_vld [MID_STAGES+1];

  fpu_exp_pipe_reg #(.Width($bits(stg_t))) u_s2 (
    .clk   (rclk),
    .rst   (rst),
    .step  (step),
    .d_vld (cap_vld),
    .d     (bias_d),
    .q_vld (dly_vld[0]),
    .q     (dly_q[0])
  );

  for (genvar i = 0; i < MID_STAGES; i++) begin : g_dly
    fpu_exp_pipe_reg #(.Width($bits(stg_t))) u_dly (
      .clk   (rclk),
      .rst   (rst),
      .step  (step),
      .d_vld (dly_vld[i]),
      .d     (dly_q[i]),
      .q_vld (dly_vld[i+1]),
      .q     (dly_q[i+1])
    );
  end

  // LZ stage: subtract leading zeros, clamp non-positive results to 0.
  stg_t             pre_lz, lz_d, lz_q;
  logic             lz_vld;
  logic [INT_W-1:0] lz_t;

  always_comb begin
    pre_lz    = dly_q[MID_STAGES];
    lz_t      = pre_lz.exp - INT_W'(lz_cnt);
    lz_exp    = pre_lz.exp;
    lz_eq0    = (lz_t == '0);
    lz_lte0_n = !lz_t[INT_W-1] && (lz_t != '0);
    lz_d      = pre_lz;
    if (!pre_lz.forced) begin
      if (lz_lte0_n) begin
        lz_d.exp = lz_t;
      end else begin
        lz_d.exp = '0;
        lz_d.uf  = 1'b1;
      end
    end
  end

  fpu_exp_pipe_reg #(.Width($bits(stg_t))) u_lz (
    .clk   (rclk),
    .rst   (rst),
    .step  (step),
    .d_vld (dly_vld[MID_STAGES]),
    .d     (lz_d),
    .q_vld (lz_vld),
    .q     (lz_q)
  );

  // INC stage
  stg_t inc_d, inc_q;
  logic inc_vld;

  always_comb begin
    inc_d = lz_q;
    if (!lz_q.forced) begin
      inc_d.exp = lz_q.exp + INT_W'(inc_exp);
    end
  end

  fpu_exp_pipe_reg #(.Width($bits(stg_t))) u_inc (
    .clk   (rclk),
    .rst   (rst),
    .step  (step),
    .d_vld (lz_vld),
    .d     (inc_d),
    .q_vld (inc_vld),
    .q     (inc_q)
  );

  // RND stage: rounding carry and overflow clamp. A clamped denormal that
  // rounds up into a nonzero exponent is no longer an underflow.
  res_t             res_d, res_q;
  logic [INT_W-1:0] rnd_sum, rnd_ones, rnd_lim;

  always_comb begin
    rnd_sum  = inc_q.exp + INT_W'(frac_cout);
    rnd_ones = inc_q.nar_out ? NarOnes : WideOnes;
    rnd_lim  = to_max_fin ? (rnd_ones - INT_W'(1)) : rnd_ones;
    res_d    = '0;
    if (inc_q.forced) begin
      res_d.exp = EXP_W'(inc_q.exp);
    end else if (rnd_sum >= rnd_ones) begin
      res_d.exp = EXP_W'(rnd_lim);
      res_d.of  = 1'b1;
    end else begin
      res_d.exp = EXP_W'(rnd_sum);
      res_d.uf  = inc_q.uf && (rnd_sum == '0);
    end
  end

  fpu_exp_pipe_reg #(.Width($bits(res_t))) u_rnd (
    .clk   (rclk),
    .rst   (rst),
    .step  (step),
    .d_vld (inc_vld),
    .d     (res_d),
    .q_vld (out_vld),
    .q     (res_q)
  );

  assign out_exp = res_q.exp;
  assign out_of  = res_q.of;
  assign out_uf  = res_q.uf;

endmodule
